apb_slave_regfile: RTL and testbench

//  APB completer sitting directly downstream of apb_bridge: consumes pselect/penable/pwrite/paddr/pwdata,

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_regbank.sv | 35 +++
 rtl/apb_slave_regfile.sv | 104 ++++++++++
 tb/tb_apb_slave_regfile.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB register-file completer
package apb_pkg;

  localparam int APB_WIDTH = 16;
  localparam int CNT_W     = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/apb_regbank.sv
// rtl/apb_regbank.sv - DEPTH x WIDTH register bank, sync write, async read, sync clear
module apb_regbank
  import apb_pkg::*;
#(
  parameter int WIDTH = APB_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_q[i] <= rst ? '0 : regs_d[i];
    end
  end

  assign rdata = regs_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with register bank and programmable wait states
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               WIDTH       = APB_WIDTH,
  parameter int               DEPTH       = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR   = '0,
  parameter int               WAIT_CYCLES = 2
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             pselect,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  output logic             pslverr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_CYCLES must be in 0..255");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_slave_regfile: DEPTH must be a power of two >= 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_range_q, in_range_d;

  // One extra bit so addresses below BASE_ADDR show up as negative instead of wrapping.
  logic [WIDTH:0]   offset;
  logic             addr_ok;
  logic [IDX_W-1:0] idx;
  logic             bank_we;
  logic [WIDTH-1:0] bank_rdata;

  assign offset  = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign addr_ok = !offset[WIDTH] && (offset < (WIDTH+1)'(DEPTH));
  assign idx     = offset[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_range_d = in_range_q;
    case (state_q)
      ST_IDLE: begin
        if (pselect && !penable) begin
          state_d    = ST_ACCESS;
          cnt_d      = WAIT_INIT;
          in_range_d = addr_ok;
        end
      end
      ST_ACCESS: begin
        if (!pselect) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_range_q <= in_range_d;
    end
  end

  assign pready  = (state_q == ST_ACCESS) && pselect && penable && (cnt_q == '0);
  assign bank_we = pready && pwrite && in_range_q;
  assign pslverr = pready && !in_range_q;
  assign prdata  = (pready && !pwrite && in_range_q) ? bank_rdata : '0;

  apb_regbank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_bank (
    .clk  (pclk),
    .rst  (preset),
    .we   (bank_we),
    .waddr(idx),
    .wdata(pwdata),
    .raddr(idx),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - self-checking bench for apb_slave_regfile (wait-2 and zero-wait builds)
module tb_apb_slave_regfile;

  localparam logic [15:0] BASE = 16'h0040;

  logic        pclk;
  logic        preset;
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [15:0] paddr  [2];
  logic [15:0] pwdata [2];
  logic        pready [2];
  logic [15:0] prdata [2];
  logic        pslverr[2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        is_read;
    logic [15:0] rdata;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[12];

  logic [15:0] model[16];

  apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut_w2 (
    .pclk(pclk), .preset(preset), .pselect(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
  );

  apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut_w0 (
    .pclk(pclk), .preset(preset), .pselect(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts #1 after a posedge, ends #1 after the posedge that completes the transfer.
  task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] exp_rd, input logic exp_err, input int exp_waits);
    exp_t e;
    int   n;
    bit   done;
    e.is_read = !wr;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.waits   = exp_waits;
    sb_q.push_back(e);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge pclk); #1;
    pen[d] = 1'b1;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge pclk);
      n++;
      if (pready[d] === 1'b1) begin
        done = 1;
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("waits@%h", a), n, e.waits);
          chk($sformatf("pslverr@%h", a), pslverr[d], e.err);
          if (e.is_read) chk($sformatf("prdata@%h", a), prdata[d], e.rdata);
        end
      end else if (n > 40) begin
        done = 1;
        chk($sformatf("timeout@%h", a), 0, 1);
        void'(sb_q.pop_front());
      end
      @(posedge pclk); #1;
    end
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    int t0;
    vecs[0]  = '{1'b1, 16'h0043, 16'hA5A5, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0043, 16'h0000, 16'hA5A5, 1'b0};
    vecs[2]  = '{1'b0, 16'h0050, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b1, 16'h003F, 16'h7777, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 16'h0040, 16'h0001, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 16'h0041, 16'h0002, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 16'h0042, 16'h0003, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'h0043, 16'h0004, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 16'h0040, 16'h0000, 16'h0001, 1'b0};
    vecs[9]  = '{1'b0, 16'h0041, 16'h0000, 16'h0002, 1'b0};
    vecs[10] = '{1'b0, 16'h0042, 16'h0000, 16'h0003, 1'b0};
    vecs[11] = '{1'b0, 16'h0043, 16'h0000, 16'h0004, 1'b0};
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_pready%0d", d), pready[d], 0);
      chk($sformatf("reset_pslverr%0d", d), pslverr[d], 0);
      chk($sformatf("reset_prdata%0d", d), prdata[d], 0);
    end
    @(posedge pclk); #1;

    // Vector table on the wait-2 build; writes 4..7 run back-to-back and are timed.
    for (int i = 0; i < 12; i++) begin
      if (i == 4) t0 = cyc;
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, 3);
      if (i == 7) chk("b2b_4_writes_cycles", cyc - t0, 16);
      if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr - BASE] = vecs[i].wdata;
    end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, BASE + 16'(i), 16'h0, model[i], 1'b0, 3);
    end

    // Zero-wait build.
    xfer(1, 1'b1, 16'h0040, 16'h1234, 16'h0, 1'b0, 1);
    xfer(1, 1'b0, 16'h0040, 16'h0, 16'h1234, 1'b0, 1);

    // Reset during the second ACCESS cycle of a write.
    idle(1);
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 16'h0041; pwdata[0] = 16'hFFFF;
    @(posedge pclk); #1 pen[0] = 1;
    @(negedge pclk); chk("rst_mid_acc1_pready", pready[0], 0);
    @(posedge pclk); #1 preset = 1;
    @(negedge pclk); chk("rst_mid_acc2_pready", pready[0], 0);
    @(posedge pclk); #1 preset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("after_rst_pready", pready[0], 0);
      chk("after_rst_pslverr", pslverr[0], 0);
      @(posedge pclk); #1;
    end
    psel[0] = 0; pen[0] = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    idle(1);
    xfer(0, 1'b0, 16'h0041, 16'h0, 16'h0000, 1'b0, 3);
    xfer(0, 1'b0, 16'h0043, 16'h0, 16'h0000, 1'b0, 3);

    // penable without SETUP must be ignored.
    idle(1);
    psel[0] = 1; pen[0] = 1; pwr[0] = 1; paddr[0] = 16'h0042; pwdata[0] = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      chk("no_setup_pready", pready[0], 0);
      @(posedge pclk); #1;
    end
    psel[0] = 0; pen[0] = 0;
    idle(1);
    xfer(0, 1'b0, 16'h0042, 16'h0, 16'h0000, 1'b0, 3);

    // pselect dropped mid-ACCESS aborts with no write.
    idle(1);
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 16'h0044; pwdata[0] = 16'h5555;
    @(posedge pclk); #1 pen[0] = 1;
    @(negedge pclk); chk("abort_acc1_pready", pready[0], 0);
    @(posedge pclk); #1 psel[0] = 0; pen[0] = 0;
    idle(2);
    xfer(0, 1'b0, 16'h0044, 16'h0, 16'h0000, 1'b0, 3);
    xfer(0, 1'b1, 16'h0044, 16'h6666, 16'h0, 1'b0, 3);
    xfer(0, 1'b0, 16'h0044, 16'h0, 16'h6666, 1'b0, 3);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
